// File: rtl/mipi_csi_rx_raw_depacker_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mipi_csi_rx_raw_depacker_ctrl
// Purpose  : Packet-level sequencer in front of the 2-lane, 8-bit-gear RAW
//            depacker. Accepts CSI packet headers and 16-bit payload beats,
//            programs the depacker packet type, forwards exactly the payload
//            of each legal RAW10/12/14 long packet, discards everything else,
//            inserts an idle flush gap after every packet and tracks
//            frame/line state.
// Ports    : clk_i, reset_i            - byte clock, sync active-high reset
//            hdr_valid_i/hdr_ready_o   - header handshake
//            hdr_type_i, hdr_wc_i      - CSI data type, word count (bytes)
//            payload_valid_i/_data_i   - payload beat (2 bytes, lane 1 low)
//            depacker_valid_o/_data_o  - gated beat stream to depacker
//            depacker_type_o           - depacker packet type (type[2:0])
//            frame_active_o            - high between FS and FE
//            line_count_o              - RAW lines completed in this frame
//            busy_o                    - not idle
//            err_wc_o, err_gap_o       - 1-cycle error pulses
// Revision : 1.0 - initial release
// ============================================================================
module mipi_csi_rx_raw_depacker_ctrl #(
    parameter int FLUSH_CYCLES     = 6,
    parameter int LINE_COUNT_WIDTH = 12
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        hdr_valid_i,
    output logic                        hdr_ready_o,
    input  logic [7:0]                  hdr_type_i,
    input  logic [15:0]                 hdr_wc_i,
    input  logic                        payload_valid_i,
    input  logic [15:0]                 payload_data_i,
    output logic                        depacker_valid_o,
    output logic [15:0]                 depacker_data_o,
    output logic [2:0]                  depacker_type_o,
    output logic                        frame_active_o,
    output logic [LINE_COUNT_WIDTH-1:0] line_count_o,
    output logic                        busy_o,
    output logic                        err_wc_o,
    output logic                        err_gap_o
);

    localparam int              c_FLUSH_W    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_LOAD = c_FLUSH_W'(FLUSH_CYCLES);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_PAYLOAD = 2'd1;
    localparam logic [1:0] c_ST_DISCARD = 2'd2;
    localparam logic [1:0] c_ST_FLUSH   = 2'd3;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0]                  r_state;
    logic [15:0]                 r_remaining;
    logic [c_FLUSH_W-1:0]        r_flush_cnt;
    logic                        r_discard_raw;
    logic                        r_dvalid;
    logic [15:0]                 r_ddata;
    logic [2:0]                  r_dtype;
    logic                        r_frame;
    logic [LINE_COUNT_WIDTH-1:0] r_line;
    logic                        r_err_wc;
    logic                        r_err_gap;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    logic [1:0]                  w_state_nxt;
    logic [15:0]                 w_remaining_nxt;
    logic [c_FLUSH_W-1:0]        w_flush_cnt_nxt;
    logic                        w_discard_raw_nxt;
    logic                        w_dvalid_nxt;
    logic [15:0]                 w_ddata_nxt;
    logic [2:0]                  w_dtype_nxt;
    logic                        w_frame_nxt;
    logic [LINE_COUNT_WIDTH-1:0] w_line_nxt;
    logic                        w_err_wc_nxt;
    logic                        w_err_gap_nxt;

    // ------------------------------------------------------------------------
    // Header decode
    // ------------------------------------------------------------------------
    logic        w_is_raw;
    logic        w_is_long;
    logic        w_wc_mult;
    logic        w_wc_legal;
    logic        w_wc_zero;
    logic [16:0] w_wc_plus1;
    logic [15:0] w_wc_half_up;

    always_comb begin
        w_is_raw  = (hdr_type_i == 8'h2B) || (hdr_type_i == 8'h2C) ||
                    (hdr_type_i == 8'h2D);
        // Long packet data types occupy 0x10..0x3F.
        w_is_long = (hdr_type_i[7:6] == 2'b00) && (hdr_type_i[5:4] != 2'b00);
        w_wc_zero = (hdr_wc_i == 16'd0);
        // The word count must cover a whole number of pixel groups so the
        // depacker ends the line aligned to its gearbox.
        case (hdr_type_i)
            8'h2B:   w_wc_mult = ((hdr_wc_i % 16'd10) == 16'd0);
            8'h2C:   w_wc_mult = ((hdr_wc_i % 16'd6)  == 16'd0);
            8'h2D:   w_wc_mult = ((hdr_wc_i % 16'd14) == 16'd0);
            default: w_wc_mult = 1'b0;
        endcase
        w_wc_legal   = w_wc_mult && !w_wc_zero;
        // Discarded packets may carry an odd byte count; the last beat is
        // half-used, so round the beat count up.
        w_wc_plus1   = {1'b0, hdr_wc_i} + 17'd1;
        w_wc_half_up = w_wc_plus1[16:1];
    end

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_remaining_nxt   = r_remaining;
        w_flush_cnt_nxt   = r_flush_cnt;
        w_discard_raw_nxt = r_discard_raw;
        w_dvalid_nxt      = 1'b0;
        w_ddata_nxt       = r_ddata;
        w_dtype_nxt       = r_dtype;
        w_frame_nxt       = r_frame;
        w_line_nxt        = r_line;
        w_err_wc_nxt      = 1'b0;
        w_err_gap_nxt     = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (hdr_valid_i) begin
                    if (hdr_type_i == 8'h00) begin
                        w_frame_nxt = 1'b1;
                        w_line_nxt  = '0;
                    end else if (hdr_type_i == 8'h01) begin
                        w_frame_nxt = 1'b0;
                    end else if (w_is_raw) begin
                        if (w_wc_legal) begin
                            w_dtype_nxt     = hdr_type_i[2:0];
                            w_remaining_nxt = {1'b0, hdr_wc_i[15:1]};
                            w_state_nxt     = c_ST_PAYLOAD;
                        end else begin
                            w_err_wc_nxt      = 1'b1;
                            w_remaining_nxt   = w_wc_half_up;
                            w_discard_raw_nxt = 1'b1;
                            if (w_wc_zero) begin
                                w_state_nxt     = c_ST_FLUSH;
                                w_flush_cnt_nxt = c_FLUSH_LOAD;
                            end else begin
                                w_state_nxt = c_ST_DISCARD;
                            end
                        end
                    end else if (w_is_long) begin
                        w_remaining_nxt   = w_wc_half_up;
                        w_discard_raw_nxt = 1'b0;
                        if (!w_wc_zero) begin
                            w_state_nxt = c_ST_DISCARD;
                        end
                    end
                end
            end

            c_ST_PAYLOAD: begin
                if (payload_valid_i) begin
                    w_dvalid_nxt    = 1'b1;
                    w_ddata_nxt     = payload_data_i;
                    w_remaining_nxt = r_remaining - 16'd1;
                    if (r_remaining == 16'd1) begin
                        w_state_nxt     = c_ST_FLUSH;
                        w_flush_cnt_nxt = c_FLUSH_LOAD;
                        w_line_nxt      = r_line + LINE_COUNT_WIDTH'(1);
                    end
                end else begin
                    // The depacker cannot absorb a hole in the burst: abort
                    // the line and flush.
                    w_err_gap_nxt   = 1'b1;
                    w_state_nxt     = c_ST_FLUSH;
                    w_flush_cnt_nxt = c_FLUSH_LOAD;
                end
            end

            c_ST_DISCARD: begin
                if (payload_valid_i) begin
                    w_remaining_nxt = r_remaining - 16'd1;
                    if (r_remaining == 16'd1) begin
                        if (r_discard_raw) begin
                            w_state_nxt     = c_ST_FLUSH;
                            w_flush_cnt_nxt = c_FLUSH_LOAD;
                        end else begin
                            w_state_nxt = c_ST_IDLE;
                        end
                    end
                end
            end

            c_ST_FLUSH: begin
                // The first FLUSH cycle still shows the final beat on the
                // registered outputs, so the counter runs FLUSH_CYCLES more
                // cycles to guarantee that many low cycles of data-valid.
                if (r_flush_cnt == '0) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - c_FLUSH_W'(1);
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state       <= c_ST_IDLE;
            r_remaining   <= '0;
            r_flush_cnt   <= '0;
            r_discard_raw <= 1'b0;
            r_dvalid      <= 1'b0;
            r_ddata       <= '0;
            r_dtype       <= 3'h3;
            r_frame       <= 1'b0;
            r_line        <= '0;
            r_err_wc      <= 1'b0;
            r_err_gap     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_remaining   <= w_remaining_nxt;
            r_flush_cnt   <= w_flush_cnt_nxt;
            r_discard_raw <= w_discard_raw_nxt;
            r_dvalid      <= w_dvalid_nxt;
            r_ddata       <= w_ddata_nxt;
            r_dtype       <= w_dtype_nxt;
            r_frame       <= w_frame_nxt;
            r_line        <= w_line_nxt;
            r_err_wc      <= w_err_wc_nxt;
            r_err_gap     <= w_err_gap_nxt;
        end
    end

    assign hdr_ready_o      = (r_state == c_ST_IDLE);
    assign busy_o           = (r_state != c_ST_IDLE);
    assign depacker_valid_o = r_dvalid;
    assign depacker_data_o  = r_ddata;
    assign depacker_type_o  = r_dtype;
    assign frame_active_o   = r_frame;
    assign line_count_o     = r_line;
    assign err_wc_o         = r_err_wc;
    assign err_gap_o        = r_err_gap;

endmodule
`default_nettype wire

// File: tb/tb_mipi_csi_rx_raw_depacker_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mipi_csi_rx_raw_depacker_ctrl
// Purpose  : Self-checking bench for mipi_csi_rx_raw_depacker_ctrl. Forwarded
//            beats are queued when driven and compared as they leave the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mipi_csi_rx_raw_depacker_ctrl;

    localparam int FLUSH_CYCLES     = 6;
    localparam int LINE_COUNT_WIDTH = 12;

    logic                        clk_i = 1'b0;
    logic                        reset_i;
    logic                        hdr_valid_i;
    logic                        hdr_ready_o;
    logic [7:0]                  hdr_type_i;
    logic [15:0]                 hdr_wc_i;
    logic                        payload_valid_i;
    logic [15:0]                 payload_data_i;
    logic                        depacker_valid_o;
    logic [15:0]                 depacker_data_o;
    logic [2:0]                  depacker_type_o;
    logic                        frame_active_o;
    logic [LINE_COUNT_WIDTH-1:0] line_count_o;
    logic                        busy_o;
    logic                        err_wc_o;
    logic                        err_gap_o;

    mipi_csi_rx_raw_depacker_ctrl #(
        .FLUSH_CYCLES    (FLUSH_CYCLES),
        .LINE_COUNT_WIDTH(LINE_COUNT_WIDTH)
    ) u_dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .hdr_valid_i     (hdr_valid_i),
        .hdr_ready_o     (hdr_ready_o),
        .hdr_type_i      (hdr_type_i),
        .hdr_wc_i        (hdr_wc_i),
        .payload_valid_i (payload_valid_i),
        .payload_data_i  (payload_data_i),
        .depacker_valid_o(depacker_valid_o),
        .depacker_data_o (depacker_data_o),
        .depacker_type_o (depacker_type_o),
        .frame_active_o  (frame_active_o),
        .line_count_o    (line_count_o),
        .busy_o          (busy_o),
        .err_wc_o        (err_wc_o),
        .err_gap_o       (err_gap_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks;
    int          n_errors;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    logic [2:0]  exp_type;
    int          exp_line;
    int          valid_cnt;
    int          err_wc_cnt;
    int          err_gap_cnt;

    // Output monitor: every forwarded beat must match the oldest queued beat
    // and carry the packet type of its header.
    always @(negedge clk_i) begin
        if (depacker_valid_o === 1'b1) begin
            valid_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_data: got %h, expected no beat", depacker_data_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if (depacker_data_o !== mon_exp) begin
                    n_errors++;
                    $display("FAIL sb_data: got %h, expected %h", depacker_data_o, mon_exp);
                end
            end
            n_checks++;
            if (depacker_type_o !== exp_type) begin
                n_errors++;
                $display("FAIL sb_type: got %h, expected %h", depacker_type_o, exp_type);
            end
        end
        if (err_wc_o === 1'b1)  err_wc_cnt++;
        if (err_gap_o === 1'b1) err_gap_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_counts;
        valid_cnt   = 0;
        err_wc_cnt  = 0;
        err_gap_cnt = 0;
    endtask

    task automatic send_hdr(input logic [7:0] t, input logic [15:0] wc);
        hdr_valid_i = 1'b1;
        hdr_type_i  = t;
        hdr_wc_i    = wc;
        tick();
        hdr_valid_i = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (hdr_ready_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        logic [36:0] obs;
        reset_i         = 1'b1;
        hdr_valid_i     = 1'b0;
        hdr_type_i      = 8'h00;
        hdr_wc_i        = 16'h0;
        payload_valid_i = 1'b0;
        payload_data_i  = 16'h0;
        repeat (3) tick();
        reset_i = 1'b0;
        tick();
        obs = {hdr_ready_o, depacker_valid_o, depacker_data_o, depacker_type_o,
               frame_active_o, line_count_o, busy_o, err_wc_o, err_gap_o};
        n_checks++;
        if (obs !== {1'b1, 1'b0, 16'h0, 3'h3, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_state: got %h, expected %h", obs,
                     {1'b1, 1'b0, 16'h0, 3'h3, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_raw10_line;
        int n;
        int bad;
        clear_counts();
        send_hdr(8'h00, 16'h0);
        n_checks++;
        if (frame_active_o !== 1'b1 || line_count_o !== 12'd0) begin
            n_errors++;
            $display("FAIL fs: got frame=%b line=%0d, expected frame=1 line=0",
                     frame_active_o, line_count_o);
        end
        exp_line = 0;
        exp_type = 3'h3;
        send_hdr(8'h2B, 16'd20);
        n_checks++;
        if (depacker_type_o !== 3'h3 || busy_o !== 1'b1 || hdr_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL raw10_accept: got type=%h busy=%b ready=%b, expected 3/1/0",
                     depacker_type_o, busy_o, hdr_ready_o);
        end
        for (int i = 0; i < 10; i++) begin
            payload_valid_i = 1'b1;
            payload_data_i  = 16'h0100 + 16'(i);
            exp_q.push_back(16'h0100 + 16'(i));
            tick();
            if (i == 0) begin
                n_checks++;
                if (depacker_valid_o !== 1'b1 || depacker_data_o !== 16'h0100) begin
                    n_errors++;
                    $display("FAIL raw10_latency: got valid=%b data=%h, expected 1/0100",
                             depacker_valid_o, depacker_data_o);
                end
            end
        end
        payload_valid_i = 1'b0;
        n   = 0;
        bad = 0;
        while (hdr_ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
            if (depacker_valid_o !== 1'b0) bad++;
        end
        exp_line = 1;
        n_checks++;
        if (n !== FLUSH_CYCLES + 1 || bad !== 0) begin
            n_errors++;
            $display("FAIL raw10_flush: got ready after %0d cycles with %0d valid, expected %0d/0",
                     n, bad, FLUSH_CYCLES + 1);
        end
        n_checks++;
        if (valid_cnt !== 10 || line_count_o !== 12'(exp_line)) begin
            n_errors++;
            $display("FAIL raw10_line: got valid_cycles=%0d line=%0d, expected 10/%0d",
                     valid_cnt, line_count_o, exp_line);
        end
        send_hdr(8'h01, 16'h0);
        n_checks++;
        if (frame_active_o !== 1'b0 || line_count_o !== 12'(exp_line)) begin
            n_errors++;
            $display("FAIL fe: got frame=%b line=%0d, expected 0/%0d",
                     frame_active_o, line_count_o, exp_line);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int bad;
        clear_counts();
        exp_type = 3'h4;
        send_hdr(8'h2C, 16'd12);
        for (int i = 0; i < 6; i++) begin
            payload_valid_i = 1'b1;
            payload_data_i  = 16'h0200 + 16'(i);
            exp_q.push_back(16'h0200 + 16'(i));
            if (i == 5) begin
                hdr_valid_i = 1'b1;
                hdr_type_i  = 8'h2B;
                hdr_wc_i    = 16'd10;
            end
            tick();
        end
        payload_valid_i = 1'b0;
        n   = 0;
        bad = 0;
        while (hdr_ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
            if (depacker_valid_o !== 1'b0 || depacker_type_o !== 3'h4) bad++;
        end
        n_checks++;
        if (n !== FLUSH_CYCLES + 1 || bad !== 0 || valid_cnt !== 6) begin
            n_errors++;
            $display("FAIL b2b_gap: got wait=%0d bad=%0d valid_cycles=%0d, expected %0d/0/6",
                     n, bad, valid_cnt, FLUSH_CYCLES + 1);
        end
        tick();
        hdr_valid_i = 1'b0;
        exp_type    = 3'h3;
        n_checks++;
        if (depacker_type_o !== 3'h3 || busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_accept: got type=%h busy=%b, expected 3/1",
                     depacker_type_o, busy_o);
        end
        for (int i = 0; i < 5; i++) begin
            payload_valid_i = 1'b1;
            payload_data_i  = 16'h0300 + 16'(i);
            exp_q.push_back(16'h0300 + 16'(i));
            tick();
        end
        payload_valid_i = 1'b0;
        wait_idle(n);
        exp_line = exp_line + 2;
        n_checks++;
        if (n !== FLUSH_CYCLES + 1 || valid_cnt !== 11 || line_count_o !== 12'(exp_line)) begin
            n_errors++;
            $display("FAIL b2b_done: got wait=%0d valid_cycles=%0d line=%0d, expected %0d/11/%0d",
                     n, valid_cnt, line_count_o, FLUSH_CYCLES + 1, exp_line);
        end
    endtask

    task automatic test_raw14_bad_wc;
        int n;
        clear_counts();
        send_hdr(8'h2D, 16'd20);
        n_checks++;
        if (err_wc_o !== 1'b1 || busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL raw14_err: got err_wc=%b busy=%b, expected 1/1", err_wc_o, busy_o);
        end
        for (int i = 0; i < 10; i++) begin
            payload_valid_i = 1'b1;
            payload_data_i  = 16'h0400 + 16'(i);
            tick();
        end
        payload_valid_i = 1'b0;
        wait_idle(n);
        n_checks++;
        if (n !== FLUSH_CYCLES + 1 || err_wc_cnt !== 1 || valid_cnt !== 0) begin
            n_errors++;
            $display("FAIL raw14_discard: got wait=%0d err_wc=%0d valid_cycles=%0d, expected %0d/1/0",
                     n, err_wc_cnt, valid_cnt, FLUSH_CYCLES + 1);
        end
        n_checks++;
        if (line_count_o !== 12'(exp_line) || depacker_type_o !== 3'h3) begin
            n_errors++;
            $display("FAIL raw14_state: got line=%0d type=%h, expected %0d/3",
                     line_count_o, depacker_type_o, exp_line);
        end
    endtask

    task automatic test_embedded_discard;
        clear_counts();
        send_hdr(8'h12, 16'd7);
        for (int i = 0; i < 8; i++) begin
            payload_valid_i = (i % 2 == 0);
            payload_data_i  = 16'($urandom);
            tick();
            if (i == 5) begin
                n_checks++;
                if (busy_o !== 1'b1) begin
                    n_errors++;
                    $display("FAIL emb_busy: got busy=%b after 3 beats, expected 1", busy_o);
                end
            end
            if (i == 6) begin
                n_checks++;
                if (busy_o !== 1'b0) begin
                    n_errors++;
                    $display("FAIL emb_idle: got busy=%b after 4 beats, expected 0", busy_o);
                end
            end
        end
        payload_valid_i = 1'b0;
        n_checks++;
        if (err_wc_cnt !== 0 || err_gap_cnt !== 0 || valid_cnt !== 0) begin
            n_errors++;
            $display("FAIL emb_quiet: got err_wc=%0d err_gap=%0d valid_cycles=%0d, expected 0/0/0",
                     err_wc_cnt, err_gap_cnt, valid_cnt);
        end
    endtask

    task automatic test_gap;
        int n;
        clear_counts();
        exp_type = 3'h3;
        send_hdr(8'h2B, 16'd40);
        for (int i = 0; i < 8; i++) begin
            payload_valid_i = 1'b1;
            payload_data_i  = 16'h0700 + 16'(i);
            exp_q.push_back(16'h0700 + 16'(i));
            tick();
        end
        payload_valid_i = 1'b0;
        tick();
        n_checks++;
        if (err_gap_o !== 1'b1 || depacker_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL gap_pulse: got err_gap=%b valid=%b busy=%b, expected 1/0/1",
                     err_gap_o, depacker_valid_o, busy_o);
        end
        wait_idle(n);
        n_checks++;
        if (n !== FLUSH_CYCLES + 1 || err_gap_cnt !== 1 || valid_cnt !== 8 ||
            line_count_o !== 12'(exp_line)) begin
            n_errors++;
            $display("FAIL gap_flush: got wait=%0d err_gap=%0d valid_cycles=%0d line=%0d, expected %0d/1/8/%0d",
                     n, err_gap_cnt, valid_cnt, line_count_o, FLUSH_CYCLES + 1, exp_line);
        end
    endtask

    task automatic test_reset_mid_packet;
        int          n;
        logic [36:0] obs;
        clear_counts();
        exp_type = 3'h3;
        send_hdr(8'h2B, 16'd40);
        for (int i = 0; i < 5; i++) begin
            payload_valid_i = 1'b1;
            payload_data_i  = 16'h0500 + 16'(i);
            if (i < 4) exp_q.push_back(16'h0500 + 16'(i));
            if (i == 4) reset_i = 1'b1;
            tick();
        end
        reset_i = 1'b0;
        obs = {hdr_ready_o, depacker_valid_o, depacker_data_o, depacker_type_o,
               frame_active_o, line_count_o, busy_o, err_wc_o, err_gap_o};
        n_checks++;
        if (obs !== {1'b1, 1'b0, 16'h0, 3'h3, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL midreset_state: got %h, expected %h", obs,
                     {1'b1, 1'b0, 16'h0, 3'h3, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0});
        end
        exp_line = 0;
        for (int i = 5; i < 8; i++) begin
            payload_data_i = 16'h0500 + 16'(i);
            tick();
        end
        payload_valid_i = 1'b0;
        n_checks++;
        if (valid_cnt !== 4 || busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_ignore: got valid_cycles=%0d busy=%b, expected 4/0",
                     valid_cnt, busy_o);
        end
        send_hdr(8'h00, 16'h0);
        send_hdr(8'h2B, 16'd10);
        for (int i = 0; i < 5; i++) begin
            payload_valid_i = 1'b1;
            payload_data_i  = 16'h0600 + 16'(i);
            exp_q.push_back(16'h0600 + 16'(i));
            tick();
        end
        payload_valid_i = 1'b0;
        wait_idle(n);
        exp_line = 1;
        n_checks++;
        if (n !== FLUSH_CYCLES + 1 || valid_cnt !== 9 || line_count_o !== 12'(exp_line) ||
            frame_active_o !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_recover: got wait=%0d valid_cycles=%0d line=%0d frame=%b, expected %0d/9/1/1",
                     n, valid_cnt, line_count_o, frame_active_o, FLUSH_CYCLES + 1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_type = 3'h3;
        exp_line = 0;
        clear_counts();
        test_reset();
        test_raw10_line();
        test_back_to_back();
        test_raw14_bad_wc();
        test_embedded_discard();
        test_gap();
        test_reset_mid_packet();
        repeat (2) tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d beats outstanding, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
